// File: rtl/mips_fetch.sv
// mips_fetch: MIPS instruction-fetch stage with PC, IF/ID register, stall, redirect and sticky fault.
module mips_fetch #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall,
  input  logic                  i_redirect,
  input  logic [31:0]           i_redirect_pc,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [31:0]           o_pc,
  output logic [31:0]           o_pc_plus4,
  output logic                  o_valid,
  output logic                  o_fault
);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d, id_pc_q, id_pc_d, id_pc4_q, id_pc4_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d, fault_q, fault_d;
  logic                  pc_ok;
  assign pc_ok      = (pc_q[1:0] == 2'b00) && (pc_q[31:ADDR_WIDTH+2] == '0);
  assign o_rom_addr = pc_q[ADDR_WIDTH+1:2];
  assign o_instr    = instr_q;
  assign o_pc       = id_pc_q;
  assign o_pc_plus4 = id_pc4_q;
  assign o_valid    = valid_q;
  assign o_fault    = fault_q;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b0;
      end
      RUN: begin
        // redirect outranks the fault check so a bad target is caught one cycle later
        if (i_redirect) begin
          pc_d    = i_redirect_pc;
          valid_d = 1'b0;
          instr_d = '0;
        end else if (!pc_ok) begin
          state_d = FAULT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else if (!i_stall) begin
          instr_d  = i_rom_data;
          id_pc_d  = pc_q;
          id_pc4_d = pc_q + 32'd4;
          valid_d  = 1'b1;
          pc_d     = pc_q + 32'd4;
        end
      end
      default: begin
        fault_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      id_pc_q  <= '0;
      id_pc4_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end
endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: directed-vector bench for mips_fetch with a combinational ROM model (word k = A000_0000+k).
module tb_mips_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data, instr, pc, pc4;
  logic        valid, fault;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  assign rom_data = 32'hA000_0000 + {24'd0, rom_addr};

  mips_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_instr(instr), .o_pc(pc), .o_pc_plus4(pc4), .o_valid(valid), .o_fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_pc4"}, pc4, 32'h0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_addr"}, {24'd0, rom_addr}, 32'd0);
  endtask

  // Releases reset, checks the BOOT bubble and the first three fetches; leaves o_pc=8, pc=0xC.
  task automatic run_boot();
    rst_n = 1'b1;
    step();
    chk("boot_valid", {31'd0, valid}, 32'd0);
    chk("boot_addr", {24'd0, rom_addr}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("seq_instr", instr, 32'hA000_0000 + k);
      chk("seq_pc", pc, 32'(4 * k));
      chk("seq_pc4", pc4, 32'(4 * k + 4));
      chk("seq_valid", {31'd0, valid}, 32'd1);
    end
  endtask

  initial begin
    #2;
    chk_cleared("rst0");
    step();
    run_boot();
    // stall holds IF/ID and the ROM address
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_instr", instr, 32'hA000_0002);
      chk("stall_pc", pc, 32'h8);
      chk("stall_addr", {24'd0, rom_addr}, 32'd3);
      chk("stall_valid", {31'd0, valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    chk("unstall_pc", pc, 32'hC);
    chk("unstall_instr", instr, 32'hA000_0003);
    // redirect overrides a simultaneous stall and inserts one bubble
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk("redir_bubble", {31'd0, valid}, 32'd0);
    chk("redir_nop", instr, 32'h0);
    chk("redir_pc_hold", pc, 32'hC);
    chk("redir_addr", {24'd0, rom_addr}, 32'h10);
    step();
    chk("redir_instr", instr, 32'hA000_0010);
    chk("redir_pc", pc, 32'h40);
    chk("redir_pc4", pc4, 32'h44);
    chk("redir_valid", {31'd0, valid}, 32'd1);
    // misaligned target faults one cycle after the bubble, then sticks
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    chk("mis_bubble", {31'd0, valid}, 32'd0);
    chk("mis_nofault", {31'd0, fault}, 32'd0);
    step();
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_valid", {31'd0, valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    step();
    redirect = 1'b0;
    chk("sticky_fault", {31'd0, fault}, 32'd1);
    chk("sticky_valid", {31'd0, valid}, 32'd0);
    chk("sticky_addr", {24'd0, rom_addr}, 32'h10);
    rst_n = 1'b0;
    #1;
    chk_cleared("rst_fault");
    step();
    run_boot();
    // running off the end of the ROM faults instead of wrapping to word 0
    redirect = 1'b1; redirect_pc = 32'h3F8;
    step();
    redirect = 1'b0;
    chk("end_bubble", {31'd0, valid}, 32'd0);
    step();
    chk("end_instr0", instr, 32'hA000_00FE);
    chk("end_pc0", pc, 32'h3F8);
    step();
    chk("end_instr1", instr, 32'hA000_00FF);
    chk("end_pc1", pc, 32'h3FC);
    chk("end_pc4", pc4, 32'h400);
    chk("end_valid", {31'd0, valid}, 32'd1);
    step();
    chk("end_fault", {31'd0, fault}, 32'd1);
    chk("end_valid_off", {31'd0, valid}, 32'd0);
    chk("end_instr_hold", instr, 32'hA000_00FF);
    step();
    chk("end_no_word0", instr, 32'hA000_00FF);
    rst_n = 1'b0;
    #1;
    step();
    run_boot();
    // async reset mid-cycle clears outputs without a clock edge
    for (int k = 0; k < 6; k++) step();
    chk("pre_rst_pc", pc, 32'h20);
    chk("pre_rst_valid", {31'd0, valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("rst_async");
    step();
    run_boot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
